// File: rtl/dmem_pkg.sv
// Shared types for the pipelined RV32I data memory: access opcodes, funct3 codes,
// init sequencer states and the request decoder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [3:0] {LB, LH, LW, LBU, LHU, SB, SH, SW, ILLEGAL} memory_op_type;

  typedef enum logic {INIT, RUN} init_state_type;

  // Unsigned widths only exist for loads; a store with 100/101 is illegal.
  function automatic memory_op_type decode_op(input logic we, input logic [2:0] funct3);
    memory_op_type op;
    op = ILLEGAL;
    case (funct3)
      F3_B:    op = we ? SB : LB;
      F3_H:    op = we ? SH : LH;
      F3_W:    op = we ? SW : LW;
      F3_BU:   op = we ? ILLEGAL : LBU;
      F3_HU:   op = we ? ILLEGAL : LHU;
      default: op = ILLEGAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store strobe/replicated write word, and load lane-select
// with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  memory_op_type st_op,
  input  logic [1:0]    st_lane,
  input  logic [31:0]   st_wdata,
  output logic [3:0]    st_strb,
  output logic [31:0]   st_word,
  input  memory_op_type ld_op,
  input  logic [1:0]    ld_lane,
  input  logic [31:0]   ld_word,
  output logic [31:0]   ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Data is replicated across lanes so the strobe alone picks the target bytes.
  always_comb begin
    st_strb = 4'b0000;
    st_word = 32'h0;
    case (st_op)
      SB: begin
        st_strb = 4'b0001 << st_lane;
        st_word = {4{st_wdata[7:0]}};
      end
      SH: begin
        st_strb = st_lane[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_wdata[15:0]}};
      end
      SW: begin
        st_strb = 4'b1111;
        st_word = st_wdata;
      end
      default: ;
    endcase
  end

  assign ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
  assign ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_data = 32'h0;
    case (ld_op)
      LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      LBU:     ld_data = {24'h0, ld_byte};
      LH:      ld_data = {{16{ld_half[15]}}, ld_half};
      LHU:     ld_data = {16'h0, ld_half};
      LW:      ld_data = ld_word;
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_pipelined.sv
// Pipelined RV32I data memory: valid/ready requests, in-order responses after
// READ_LATENCY cycles, access-fault reporting and a zeroing init sequencer.
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam int          LAST  = READ_LATENCY - 1;
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

  init_state_type    state_reg;
  logic [IDX_W-1:0]  init_idx_reg;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       ram_q;

  logic              stall, accept;
  logic [31:0]       offset;
  logic [IDX_W-1:0]  widx;
  logic [1:0]        lane;
  memory_op_type     dec_op;
  logic              misaligned, out_of_range, dec_err;
  logic [3:0]        st_strb;
  logic [31:0]       st_word, ld_data, last_word;

  logic [READ_LATENCY-1:0] vld_reg, err_reg;
  memory_op_type           op_reg   [READ_LATENCY];
  logic [1:0]              lane_reg [READ_LATENCY];

  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = (state_reg == RUN) && !stall;
  assign accept    = req_valid && req_ready;

  assign offset = req_addr - BASE_ADDR;
  assign widx   = offset[IDX_W+1:2];
  assign lane   = offset[1:0];
  assign dec_op = decode_op(req_we, req_funct3);

  always_comb begin
    misaligned = 1'b0;
    case (dec_op)
      LH, LHU, SH: misaligned = lane[0];
      LW, SW:      misaligned = (lane != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

  // Offset wraps when req_addr < BASE_ADDR, so that case is checked explicitly.
  assign out_of_range = (req_addr < BASE_ADDR) || (offset >= SPAN);
  assign dec_err      = (dec_op == ILLEGAL) || misaligned || out_of_range;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= INIT;
      init_idx_reg <= '0;
      init_done    <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          init_idx_reg <= init_idx_reg + 1'b1;
          if (init_idx_reg == IDX_W'(DEPTH_WORDS - 1)) begin
            state_reg <= RUN;
            init_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Single write port shared by the init sequencer and byte-strobed stores.
  always_ff @(posedge clk) begin
    if (state_reg == INIT) begin
      mem[init_idx_reg] <= 32'h0;
    end else if (accept && req_we && !dec_err) begin
      for (int b = 0; b < 4; b++) begin
        if (st_strb[b]) mem[widx][b*8 +: 8] <= st_word[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) ram_q <= mem[widx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_reg <= '0;
      err_reg <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        op_reg[i]   <= ILLEGAL;
        lane_reg[i] <= 2'b00;
      end
    end else if (!stall) begin
      vld_reg[0]  <= accept;
      err_reg[0]  <= dec_err;
      op_reg[0]   <= dec_op;
      lane_reg[0] <= lane;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_reg[i]  <= vld_reg[i-1];
        err_reg[i]  <= err_reg[i-1];
        op_reg[i]   <= op_reg[i-1];
        lane_reg[i] <= lane_reg[i-1];
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_no_dpipe
      assign last_word = ram_q;
    end else begin : g_dpipe
      logic [31:0] dpipe_reg [READ_LATENCY-1];
      always_ff @(posedge clk) begin
        if (!stall) begin
          dpipe_reg[0] <= ram_q;
          for (int i = 1; i < READ_LATENCY - 1; i++) dpipe_reg[i] <= dpipe_reg[i-1];
        end
      end
      assign last_word = dpipe_reg[READ_LATENCY-2];
    end
  endgenerate

  dmem_lane_align u_lane_align (
    .st_op    (dec_op),
    .st_lane  (lane),
    .st_wdata (req_wdata),
    .st_strb  (st_strb),
    .st_word  (st_word),
    .ld_op    (op_reg[LAST]),
    .ld_lane  (lane_reg[LAST]),
    .ld_word  (last_word),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (!stall) begin
      rsp_valid <= vld_reg[LAST];
      rsp_err   <= vld_reg[LAST] && err_reg[LAST];
      rsp_rdata <= (vld_reg[LAST] && !err_reg[LAST]) ? ld_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_pipelined.sv
// Directed bench for dmem_pipelined: init, lane/extend, faults, stall burst
// and mid-flight reset, with an in-order expected-response queue.
module tb_dmem_pipelined;

  localparam int          DEPTH = 64;
  localparam int          LAT   = 3;
  localparam logic [31:0] BASE  = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, init_done;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;
  int nrsp  = 0;
  logic in_run = 1'b0;

  logic [31:0] exp_d_q [$];
  logic        exp_e_q [$];

  logic [31:0] prev_rdata;
  logic        prev_err;
  logic        prev_stall = 1'b0;

  logic [31:0] tbl [8] = '{32'h0102_0304, 32'h1111_2222, 32'h8000_0001, 32'h7FFF_FFFF,
                           32'hA5A5_5A5A, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678};

  always #5 clk = ~clk;

  dmem_pipelined #(
    .DEPTH_WORDS  (DEPTH),
    .READ_LATENCY (LAT),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_done  (init_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  // Response monitor: sampled on the falling edge, a take happens at the next rise.
  always @(negedge clk) begin
    if (reset_n) begin
      if (in_run) chk("ready", {31'h0, req_ready}, {31'h0, !(rsp_valid && !rsp_ready)});
      if (prev_stall && rsp_valid) begin
        chk("hold_data", rsp_rdata, prev_rdata);
        chk("hold_err", {31'h0, rsp_err}, {31'h0, prev_err});
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_rdata = rsp_rdata;
      prev_err   = rsp_err;
      if (rsp_valid && rsp_ready) begin
        if (exp_d_q.size() == 0) begin
          chk("spurious", 32'(exp_d_q.size()), 32'd1);
        end else begin
          nrsp++;
          $display("rsp %0d rdata=%08h err=%0d want %08h/%0d", nrsp, rsp_rdata, rsp_err,
                   exp_d_q[0], exp_e_q[0]);
          chk($sformatf("rsp%0d_data", nrsp), rsp_rdata, exp_d_q.pop_front());
          chk($sformatf("rsp%0d_err", nrsp), {31'h0, rsp_err}, {31'h0, exp_e_q.pop_front()});
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
    int n;
    exp_d_q.push_back(exp_d);
    exp_e_q.push_back(exp_e);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      chk("accept_timeout", {31'h0, req_ready}, 32'd1);
      void'(exp_d_q.pop_back());
      void'(exp_e_q.pop_back());
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_d_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(exp_d_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int cycles;
    cycles = 0;
    while (!init_done && cycles < 4 * DEPTH) begin
      @(posedge clk);
      #1;
      cycles++;
      if (!init_done) chk({tag, "_busy_ready"}, {31'h0, req_ready}, 32'd0);
    end
    chk({tag, "_cycles"}, 32'(cycles), 32'(DEPTH));
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
    chk("rst_init_done", {31'h0, init_done}, 32'd0);
    reset_n = 1'b1;
    wait_init("init1");
    in_run = 1'b1;

    send(1'b0, 3'b010, BASE + 32'h00, 32'h0, 32'h0000_0000, 1'b0);

    // Lane select and extension, back-to-back after the store
    send(1'b1, 3'b010, BASE + 32'h10, 32'h8070_F0FF, 32'h0, 1'b0);
    send(1'b0, 3'b000, BASE + 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b0);
    send(1'b0, 3'b100, BASE + 32'h11, 32'h0, 32'h0000_00F0, 1'b0);
    send(1'b0, 3'b001, BASE + 32'h12, 32'h0, 32'hFFFF_8070, 1'b0);
    send(1'b0, 3'b101, BASE + 32'h12, 32'h0, 32'h0000_8070, 1'b0);
    send(1'b1, 3'b000, BASE + 32'h21, 32'hFFFF_FFAB, 32'h0, 1'b0);
    send(1'b0, 3'b010, BASE + 32'h20, 32'h0, 32'h0000_AB00, 1'b0);
    send(1'b1, 3'b001, BASE + 32'h22, 32'h1234_BEEF, 32'h0, 1'b0);
    send(1'b0, 3'b010, BASE + 32'h20, 32'h0, 32'hBEEF_AB00, 1'b0);
    drain();

    // Faults: each followed by a read-back of word 0
    send(1'b1, 3'b010, BASE + 32'h00, 32'hCAFE_BABE, 32'h0, 1'b0);
    send(1'b0, 3'b001, BASE + 32'h03, 32'h0, 32'h0, 1'b1);
    send(1'b0, 3'b010, BASE + 32'h00, 32'h0, 32'hCAFE_BABE, 1'b0);
    send(1'b1, 3'b010, BASE + 32'h02, 32'h1234_5678, 32'h0, 1'b1);
    send(1'b0, 3'b010, BASE + 32'h00, 32'h0, 32'hCAFE_BABE, 1'b0);
    send(1'b0, 3'b010, BASE + 32'h100, 32'h0, 32'h0, 1'b1);
    send(1'b1, 3'b010, BASE + 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b1);
    send(1'b0, 3'b010, BASE + 32'h00, 32'h0, 32'hCAFE_BABE, 1'b0);
    send(1'b0, 3'b011, BASE + 32'h00, 32'h0, 32'h0, 1'b1);
    send(1'b1, 3'b011, BASE + 32'h00, 32'h0, 32'h0, 1'b1);
    send(1'b0, 3'b110, BASE + 32'h00, 32'h0, 32'h0, 1'b1);
    send(1'b1, 3'b100, BASE + 32'h00, 32'h11, 32'h0, 1'b1);
    send(1'b0, 3'b010, BASE + 32'h00, 32'h0, 32'hCAFE_BABE, 1'b0);
    send(1'b0, 3'b010, BASE - 32'h4, 32'h0, 32'h0, 1'b1);
    send(1'b1, 3'b001, BASE + 32'h01, 32'h7777, 32'h0, 1'b1);
    send(1'b1, 3'b000, BASE + 32'h03, 32'h5A, 32'h0, 1'b0);
    send(1'b0, 3'b010, BASE + 32'h00, 32'h0, 32'h5AFE_BABE, 1'b0);
    drain();

    // Burst of 8 loads with a 5-cycle consumer stall in the middle
    for (int i = 0; i < 8; i++) send(1'b1, 3'b010, BASE + 32'h40 + 32'(4 * i), tbl[i], 32'h0, 1'b0);
    drain();
    fork
      begin
        for (int i = 0; i < 8; i++) send(1'b0, 3'b010, BASE + 32'h40 + 32'(4 * i), 32'h0, tbl[i], 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset with the output register and three pipeline stages occupied
    for (int i = 0; i < 5; i++) send(1'b0, 3'b010, BASE + 32'h40 + 32'(4 * i), 32'h0, tbl[i], 1'b0);
    chk("pre_rst_valid", {31'h0, rsp_valid}, 32'd1);
    in_run  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst2_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst2_init_done", {31'h0, init_done}, 32'd0);
    chk("rst2_req_ready", {31'h0, req_ready}, 32'd0);
    exp_d_q.delete();
    exp_e_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_init("init2");
    in_run = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(1'b0, 3'b010, BASE + 32'h40, 32'h0, 32'h0, 1'b0);
    drain();
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
